// File: rtl/axis_pattern_sequencer.sv
// AXI-Stream test-pattern source: emits pkt_count packets of pkt_len incrementing beats,
// separated by gap_cycles idle cycles, with abort honoured only at packet boundaries.
module axis_pattern_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned GAP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [CNT_WIDTH-1:0]  pkt_count,
  input  logic [GAP_WIDTH-1:0]  gap_cycles,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [CNT_WIDTH-1:0]  pkts_sent,
  output logic [DATA_WIDTH-1:0] axis_tdata,
  output logic                  axis_tvalid,
  output logic                  axis_tlast,
  input  logic                  axis_tready
);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e                state_q;
  logic [LEN_WIDTH-1:0]  len_q, beat_q;
  logic [CNT_WIDTH-1:0]  cnt_q, pkts_sent_q;
  logic [GAP_WIDTH-1:0]  gap_q, gap_cnt_q;
  logic [DATA_WIDTH-1:0] pat_q, tdata_q;
  logic                  abort_pend_q, busy_q, done_q, aborted_q, tvalid_q, tlast_q;

  logic                  hs, pend_now, next_last, last_pkt, run_end, start_ok;
  logic [DATA_WIDTH-1:0] pat_inc;
  logic [LEN_WIDTH-1:0]  beat_inc;
  logic [CNT_WIDTH-1:0]  sent_inc;

  always_comb begin
    hs        = tvalid_q & axis_tready;
    pend_now  = abort_pend_q | abort;
    pat_inc   = pat_q + DATA_WIDTH'(1);
    beat_inc  = beat_q + LEN_WIDTH'(1);
    sent_inc  = pkts_sent_q + CNT_WIDTH'(1);
    next_last = (beat_inc == (len_q - LEN_WIDTH'(1)));
    last_pkt  = (sent_inc == cnt_q);
    run_end   = last_pkt | pend_now;
    start_ok  = start & (pkt_len != '0) & (pkt_count != '0);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StIdle;
      len_q        <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      beat_q       <= '0;
      gap_cnt_q    <= '0;
      pat_q        <= '0;
      tdata_q      <= '0;
      pkts_sent_q  <= '0;
      abort_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_ok) begin
            state_q      <= StSend;
            len_q        <= pkt_len;
            cnt_q        <= pkt_count;
            gap_q        <= gap_cycles;
            beat_q       <= '0;
            pat_q        <= '0;
            tdata_q      <= '0;
            pkts_sent_q  <= '0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            busy_q       <= 1'b1;
            tvalid_q     <= 1'b1;
            tlast_q      <= (pkt_len == LEN_WIDTH'(1));
          end
        end
        StSend: begin
          if (!hs) begin
            abort_pend_q <= pend_now;
          end else if (!tlast_q) begin
            pat_q        <= pat_inc;
            beat_q       <= beat_inc;
            tdata_q      <= pat_inc;
            tlast_q      <= next_last;
            abort_pend_q <= pend_now;
          end else begin
            pat_q       <= pat_inc;
            beat_q      <= '0;
            pkts_sent_q <= sent_inc;
            if (run_end) begin
              state_q      <= StIdle;
              tvalid_q     <= 1'b0;
              tdata_q      <= '0;
              tlast_q      <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              // A run that finishes its last packet counts as normal even if abort was raised.
              aborted_q    <= pend_now & ~last_pkt;
              abort_pend_q <= 1'b0;
            end else if (gap_q == '0) begin
              tdata_q <= pat_inc;
              tlast_q <= (len_q == LEN_WIDTH'(1));
            end else begin
              state_q   <= StGap;
              tvalid_q  <= 1'b0;
              tdata_q   <= '0;
              tlast_q   <= 1'b0;
              gap_cnt_q <= gap_q - GAP_WIDTH'(1);
            end
          end
        end
        StGap: begin
          if (pend_now) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            aborted_q    <= 1'b1;
            abort_pend_q <= 1'b0;
          end else if (gap_cnt_q == '0) begin
            state_q  <= StSend;
            tvalid_q <= 1'b1;
            tdata_q  <= pat_q;
            tlast_q  <= (len_q == LEN_WIDTH'(1));
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_WIDTH'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign pkts_sent   = pkts_sent_q;
  assign axis_tdata  = tdata_q;
  assign axis_tvalid = tvalid_q;
  assign axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_pattern_sequencer.sv
// Directed bench for axis_pattern_sequencer with a beat scoreboard fed at each start.
module tb_axis_pattern_sequencer;

  logic        clk = 1'b0;
  logic        resetn, start, abort, axis_tready;
  logic [15:0] pkt_len, pkt_count;
  logic [7:0]  gap_cycles;
  logic        busy, done, aborted, axis_tvalid, axis_tlast;
  logic [15:0] pkts_sent;
  logic [7:0]  axis_tdata;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          hs_cnt   = 0;
  int          hs_mark;
  logic [7:0]  last_tlast_data = '0;
  logic        wrap_seen = 1'b0;
  logic        mon_en = 1'b0;
  logic [8:0]  exp_q[$];

  axis_pattern_sequencer dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .abort       (abort),
    .pkt_len     (pkt_len),
    .pkt_count   (pkt_count),
    .gap_cycles  (gap_cycles),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .pkts_sent   (pkts_sent),
    .axis_tdata  (axis_tdata),
    .axis_tvalid (axis_tvalid),
    .axis_tlast  (axis_tlast),
    .axis_tready (axis_tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected beats of npkts packets of len beats, counter starting from 0.
  task automatic push_run(input int len, input int npkts);
    for (int i = 0; i < len * npkts; i++) begin
      logic [8:0] e;
      e = {((i % len) == len - 1), 8'(i)};
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input int len, input int cnt, input int gap);
    pkt_len    = 16'(len);
    pkt_count  = 16'(cnt);
    gap_cycles = 8'(gap);
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i = 0;
    while (!done && i < budget) begin
      tick();
      i++;
    end
    check(tag, done, 1);
  endtask

  // Monitor: scoreboard pop on handshake, stall stability and idle-bus invariants.
  initial begin
    logic       prev_stall = 1'b0;
    logic       prev_rst   = 1'b0;
    logic [7:0] prev_data  = '0;
    logic       prev_last  = 1'b0;
    logic [7:0] prev_hs_data = '0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (prev_stall && prev_rst) begin
          check("stall_valid", axis_tvalid, 1);
          check("stall_data", axis_tdata, prev_data);
          check("stall_last", axis_tlast, prev_last);
        end
        if (!axis_tvalid) begin
          check("idle_tdata", axis_tdata, 0);
          check("idle_tlast", axis_tlast, 0);
        end
        if (axis_tvalid && axis_tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", axis_tdata, 32'hffff_ffff);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", axis_tdata, e[7:0]);
            check("beat_last", axis_tlast, e[8]);
          end
          if (hs_cnt > 0 && prev_hs_data == 8'd255 && axis_tdata == 8'd0) wrap_seen = 1'b1;
          if (axis_tlast) last_tlast_data = axis_tdata;
          prev_hs_data = axis_tdata;
          hs_cnt++;
        end
      end
      prev_stall = axis_tvalid & ~axis_tready;
      prev_rst   = resetn;
      prev_data  = axis_tdata;
      prev_last  = axis_tlast;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; start = 1'b0; abort = 1'b0; axis_tready = 1'b1;
    pkt_len = '0; pkt_count = '0; gap_cycles = '0;
    tick(); tick();
    check("rst_tvalid", axis_tvalid, 0);
    check("rst_tdata", axis_tdata, 0);
    check("rst_tlast", axis_tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_pkts_sent", pkts_sent, 0);
    resetn = 1'b1;
    mon_en = 1'b1;
    tick();

    // 1: back-to-back packets, exact cycle timing
    push_run(4, 2);
    do_start(4, 2, 0);
    check("t1_busy", busy, 1);
    for (int k = 0; k < 8; k++) begin
      check("t1_valid", axis_tvalid, 1);
      check("t1_data", axis_tdata, k);
      check("t1_last", axis_tlast, (k == 3 || k == 7));
      tick();
    end
    check("t1_done", done, 1);
    check("t1_busy_end", busy, 0);
    check("t1_pkts", pkts_sent, 2);
    tick();
    check("t1_done_pulse", done, 0);

    // 2: inter-packet gap of 3
    push_run(2, 2);
    do_start(2, 2, 3);
    check("t2_d0", axis_tdata, 0);
    tick();
    check("t2_d1_last", axis_tlast, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_gap_valid", axis_tvalid, 0);
    end
    tick();
    check("t2_d2_valid", axis_tvalid, 1);
    check("t2_d2", axis_tdata, 2);
    tick();
    check("t2_d3", axis_tdata, 3);
    tick();
    check("t2_done", done, 1);

    // 3: backpressure stall then toggling ready
    hs_mark = hs_cnt;
    push_run(4, 2);
    do_start(4, 2, 0);
    tick();
    axis_tready = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    for (int k = 0; k < 60 && !done; k++) begin
      axis_tready = ~axis_tready;
      tick();
    end
    check("t3_done", done, 1);
    check("t3_hs_count", hs_cnt - hs_mark, 8);
    check("t3_q_empty", exp_q.size(), 0);
    axis_tready = 1'b1;
    tick();

    // 4: counter wrap across a 300-beat packet
    wrap_seen = 1'b0;
    push_run(300, 1);
    do_start(300, 1, 0);
    wait_done("t4_done", 400);
    check("t4_wrap", wrap_seen, 1);
    check("t4_last_data", last_tlast_data, 43);
    tick();

    // 5: abort mid-packet completes packet 0 only
    push_run(16, 1);
    do_start(16, 4, 0);
    for (int k = 0; k < 5; k++) tick();
    check("t5_beat5", axis_tdata, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done("t5_done", 40);
    check("t5_aborted", aborted, 1);
    check("t5_pkts", pkts_sent, 1);
    check("t5_last_data", last_tlast_data, 15);
    check("t5_busy", busy, 0);
    for (int k = 0; k < 4; k++) tick();
    check("t5_no_more_beats", exp_q.size(), 0);

    // 5b: abort in a gap ends the run at once
    push_run(2, 1);
    do_start(2, 3, 4);
    tick(); tick();
    check("t5b_in_gap", axis_tvalid, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5b_done", done, 1);
    check("t5b_aborted", aborted, 1);
    check("t5b_busy", busy, 0);
    check("t5b_pkts", pkts_sent, 1);
    for (int k = 0; k < 6; k++) tick();

    // 5c: abort on final beat of last packet is a normal completion
    push_run(2, 1);
    do_start(2, 1, 0);
    tick();
    check("t5c_last", axis_tlast, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5c_done", done, 1);
    check("t5c_aborted", aborted, 0);
    tick();

    // 6: zero length start ignored
    do_start(0, 3, 0);
    check("t6_zero_busy", busy, 0);
    check("t6_zero_valid", axis_tvalid, 0);
    tick();
    check("t6_zero_done", done, 0);

    // 6: second start mid-run ignored
    push_run(8, 1);
    do_start(8, 1, 0);
    tick(); tick();
    do_start(2, 5, 0);
    wait_done("t6_restart_done", 30);
    check("t6_restart_pkts", pkts_sent, 1);
    tick(); tick();
    check("t6_restart_q", exp_q.size(), 0);

    // 6: reset in the middle of packet 1
    push_run(4, 3);
    do_start(4, 3, 0);
    for (int k = 0; k < 5; k++) tick();
    check("t6_pre_rst_pkts", pkts_sent, 1);
    check("t6_pre_rst_data", axis_tdata, 5);
    resetn = 1'b0;
    axis_tready = 1'b0;
    exp_q.delete();
    tick();
    check("t6_rst_valid", axis_tvalid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_pkts", pkts_sent, 0);
    resetn = 1'b1;
    axis_tready = 1'b1;
    tick();
    push_run(3, 1);
    do_start(3, 1, 0);
    check("t6_clean_d0", axis_tdata, 0);
    wait_done("t6_clean_done", 20);
    check("t6_clean_pkts", pkts_sent, 1);
    tick();
    check("final_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_pattern_sequencer.md
Name: axis_pattern_sequencer

Overview:
Run-time-configurable AXI-Stream test-pattern source with a control FSM. On a start pulse it emits a burst of `pkt_count` packets, each `pkt_len` beats long. Beat data is an incrementing counter, and consecutive packets are separated by `gap_cycles` idle cycles. It obeys tready backpressure. It sits ahead of the DMA stream (S2MM) path and replaces the fixed free-running pattern source for throughput and packet-boundary testing.

Parameters:
- DATA_WIDTH, 8, width of axis_tdata and of the pattern counter.
- LEN_WIDTH, 16, width of the packet-length field (beats per packet).
- CNT_WIDTH, 16, width of the packet-count field and the pkts_sent status.
- GAP_WIDTH, 8, width of the inter-packet gap field (cycles).

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE.
- abort  in  1  level or pulse; requests the run to stop at the next packet boundary.
- pkt_len  in  LEN_WIDTH  beats per packet; sampled at an accepted start.
- pkt_count  in  CNT_WIDTH  packets per run; sampled at an accepted start.
- gap_cycles  in  GAP_WIDTH  idle cycles between packets; sampled at an accepted start.
- busy  out  1  high from the cycle after an accepted start until run end.
- done  out  1  one-cycle pulse at run end (normal completion or abort).
- aborted  out  1  set with done when the run ended by abort; cleared on the next accepted start.
- pkts_sent  out  CNT_WIDTH  packets completed in the current or last run.
- axis_tdata  out  DATA_WIDTH  pattern data.
- axis_tvalid  out  1  AXIS valid.
- axis_tlast  out  1  high on the final beat of each packet.
- axis_tready  in  1  AXIS ready from the downstream sink.

Behaviour:
- All outputs are registered.
- Reset (resetn=0 at a clock edge): state=IDLE; all outputs 0; internal counters 0. Reset applies mid-run with no flush; the partial packet is abandoned.
- FSM states are IDLE, SEND and GAP.
- IDLE:
  - An accepted start is start=1 with pkt_len!=0 and pkt_count!=0.
  - On an accepted start: latch the config; clear pkts_sent and aborted; set beat=0; go to SEND.
  - In the next cycle: tvalid=1, tdata=0, tlast=(pkt_len==1), busy=1. Latency from start to first valid beat is 1 cycle.
  - start with a zero pkt_len or pkt_count is ignored: no busy, no done.
- SEND:
  - A handshake occurs on tvalid&&tready.
  - Without a handshake, tdata, tvalid and tlast hold stable. tvalid never drops before a handshake.
  - On a handshake the pattern counter increments modulo 2^DATA_WIDTH. It is not reset between packets within a run; it resets to 0 only at an accepted start.
  - tlast is asserted exactly when beat==pkt_len-1.
- Handshake on a non-last beat: present the next beat in the next cycle with no bubble.
- Handshake on a last beat:
  - pkts_sent increments.
  - If pkts_sent reaches pkt_count, or abort is pending: go to IDLE. The next cycle has tvalid=0, busy=0, done=1, and aborted=1 if abort was pending.
  - Otherwise, if gap_cycles==0: present beat 0 of the next packet in the next cycle (back-to-back).
  - Otherwise: go to GAP with tvalid=0.
- GAP:
  - tvalid=0 for exactly gap_cycles cycles, then the next packet's first beat is valid.
  - An abort seen in GAP ends the run immediately: next cycle done=1, aborted=1, busy=0.
- Abort rules:
  - Abort is sampled every cycle while busy and latched as pending.
  - It never truncates a packet. The current packet always completes through tlast.
  - An abort on the same cycle as the final beat of the last packet gives a normal completion with aborted=0.
- start while busy is ignored. Config inputs are ignored except at an accepted start.
- tlast is never asserted with tvalid=0. tdata is 0 whenever tvalid=0.

Test Plan:
1. pkt_len=4, pkt_count=2, gap=0, tready=1, start at cycle 0:
   - tdata 0..7 valid in cycles 1–8.
   - tlast on data 3 and 7.
   - done=1 and busy=0 in cycle 9; pkts_sent=2.
2. pkt_len=2, pkt_count=2, gap=3, tready=1:
   - Beats 0,1 are followed by exactly 3 cycles of tvalid=0, then beats 2,3.
   - done one cycle after the beat-3 handshake.
3. Backpressure with pkt_len=4, pkt_count=2: hold tready=0 for 5 cycles mid-packet, then toggle it every cycle.
   - tdata/tlast stable while stalled; no skipped or duplicated values.
   - Exactly 8 handshakes with data 0..7.
4. Wrap-around with pkt_len=300, pkt_count=1:
   - Data 255 is followed by 0.
   - tlast on the 300th beat, with tdata=43.
5. Abort with pkt_len=16, pkt_count=4: pulse abort during beat 5 of packet 0.
   - Packet 0 completes through tlast (data 15).
   - Next cycle: done=1, aborted=1, pkts_sent=1, no further valid beats.
6. Edge cases:
   - start with pkt_len=0 produces no busy and no done.
   - A second start mid-run is ignored.
   - resetn=0 mid-packet clears tvalid/busy/pkts_sent in the next cycle.
   - A subsequent start then runs cleanly from data 0.
